// File: rtl/icache_line_buffer_if.sv
// icache_line_buffer_if: fetch, icache and TLB signals of the instruction line buffer.
interface icache_line_buffer_if #(
    parameter int ADDR_SIZE = 40,
    parameter int LINE_BITS = 128
);
    logic                 fetch_valid_i;
    logic [ADDR_SIZE-1:0] fetch_vaddr_i;
    logic                 fetch_flush_i;
    logic                 fetch_resp_valid_o;
    logic [31:0]          fetch_resp_data_o;
    logic                 fetch_resp_xcpt_o;
    logic                 icache_req_valid_o;
    logic                 icache_req_ready_i;
    logic [ADDR_SIZE-1:0] icache_req_vaddr_o;
    logic                 icache_req_kill_o;
    logic                 icache_resp_valid_i;
    logic [ADDR_SIZE-1:0] icache_resp_vaddr_i;
    logic [LINE_BITS-1:0] icache_resp_data_i;
    logic                 tlb_miss_i;
    logic                 tlb_xcpt_i;
    logic                 ptw_resp_valid_i;

    modport master (
        output fetch_valid_i, fetch_vaddr_i, fetch_flush_i, icache_req_ready_i,
               icache_resp_valid_i, icache_resp_vaddr_i, icache_resp_data_i,
               tlb_miss_i, tlb_xcpt_i, ptw_resp_valid_i,
        input  fetch_resp_valid_o, fetch_resp_data_o, fetch_resp_xcpt_o,
               icache_req_valid_o, icache_req_vaddr_o, icache_req_kill_o
    );

    modport slave (
        input  fetch_valid_i, fetch_vaddr_i, fetch_flush_i, icache_req_ready_i,
               icache_resp_valid_i, icache_resp_vaddr_i, icache_resp_data_i,
               tlb_miss_i, tlb_xcpt_i, ptw_resp_valid_i,
        output fetch_resp_valid_o, fetch_resp_data_o, fetch_resp_xcpt_o,
               icache_req_valid_o, icache_req_vaddr_o, icache_req_kill_o
    );
endinterface

// File: rtl/icache_line_buffer.sv
// icache_line_buffer: small fully-associative line buffer between fetch and the icache,
// with round-robin fill, one outstanding request and optional next-line prefetch.
module icache_line_buffer #(
    parameter int ADDR_SIZE   = 40,
    parameter int LINE_BITS   = 128,
    parameter int NUM_ENTRIES = 4,
    parameter int PREFETCH_EN = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    icache_line_buffer_if.slave bus
);
    localparam int OFFSET = $clog2(LINE_BITS / 8);
    localparam int TW     = ADDR_SIZE - OFFSET;
    localparam int RW     = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, TLBMISS} state_t;

    state_t                 state;
    logic [NUM_ENTRIES-1:0] valid;
    logic [TW-1:0]          tags  [NUM_ENTRIES];
    logic [LINE_BITS-1:0]   lines [NUM_ENTRIES];
    logic [RW-1:0]          rr, widx_fill;
    logic [TW-1:0]          otag, ftag, rtag, nxt_tag, req_tag;
    logic                   opf;
    logic [OFFSET-3:0]      widx;
    logic [LINE_BITS-1:0]   hit_line;
    logic                   go, tag_hit, nxt_res, res, hit, demand, pref, req;
    logic                   wait_ok, xr_ev, xr, miss_ev, fill, fwd;
    logic                   unused_bits;

    assign ftag        = bus.fetch_vaddr_i[ADDR_SIZE-1:OFFSET];
    assign rtag        = bus.icache_resp_vaddr_i[ADDR_SIZE-1:OFFSET];
    assign nxt_tag     = ftag + TW'(1);
    assign widx        = bus.fetch_vaddr_i[OFFSET-1:2];
    assign unused_bits = ^{bus.fetch_vaddr_i[1:0], bus.icache_resp_vaddr_i[OFFSET-1:0]};

    // Fill target is the resident copy of otag if any, so refills never duplicate a line
    always_comb begin
        tag_hit   = 1'b0;
        nxt_res   = 1'b0;
        res       = 1'b0;
        hit_line  = '0;
        widx_fill = rr;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid[i] && tags[i] == ftag) begin
                tag_hit  = 1'b1;
                hit_line = lines[i];
            end
            if (valid[i] && tags[i] == nxt_tag) nxt_res = 1'b1;
            if (valid[i] && tags[i] == otag) begin
                res       = 1'b1;
                widx_fill = RW'(i);
            end
        end
    end

    assign go      = !rst_i && !bus.fetch_flush_i;
    assign hit     = go && bus.fetch_valid_i && tag_hit;
    assign demand  = go && state == IDLE && bus.fetch_valid_i && !tag_hit;
    assign pref    = PREFETCH_EN != 0 && state == IDLE && hit && !nxt_res;
    assign req     = demand || pref;
    assign req_tag = demand ? ftag : nxt_tag;
    assign wait_ok = go && state == WAIT;
    assign xr_ev   = wait_ok && bus.tlb_xcpt_i;
    assign xr      = xr_ev && !opf;
    assign miss_ev = wait_ok && !bus.tlb_xcpt_i && bus.tlb_miss_i;
    assign fill    = wait_ok && !bus.tlb_xcpt_i && !bus.tlb_miss_i && bus.icache_resp_valid_i && rtag == otag;
    assign fwd     = fill && !opf && bus.fetch_valid_i && ftag == otag;

    assign bus.fetch_resp_valid_o = hit || fwd || xr;
    assign bus.fetch_resp_xcpt_o  = xr;
    assign bus.fetch_resp_data_o  = xr  ? 32'd0 :
                                    hit ? hit_line[widx*32 +: 32] :
                                    fwd ? bus.icache_resp_data_i[widx*32 +: 32] : 32'd0;
    assign bus.icache_req_valid_o = req;
    assign bus.icache_req_vaddr_o = req ? {req_tag, {OFFSET{1'b0}}} : '0;
    assign bus.icache_req_kill_o  = !rst_i && (bus.tlb_miss_i || bus.tlb_xcpt_i ||
                                    (bus.fetch_flush_i && state == WAIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            valid <= '0;
            rr    <= '0;
            otag  <= '0;
            opf   <= 1'b0;
        end else if (bus.fetch_flush_i) begin
            state <= IDLE;
            valid <= '0;
        end else if (state == IDLE) begin
            if (req && bus.icache_req_ready_i) begin
                state <= WAIT;
                otag  <= req_tag;
                opf   <= !demand;
            end
        end else if (state == WAIT) begin
            if (xr_ev) state <= IDLE;
            else if (miss_ev) state <= TLBMISS;
            else if (fill) begin
                state            <= IDLE;
                valid[widx_fill] <= 1'b1;
                tags[widx_fill]  <= otag;
                lines[widx_fill] <= bus.icache_resp_data_i;
                if (!res) rr <= (rr == RW'(NUM_ENTRIES - 1)) ? '0 : rr + RW'(1);
            end
        end else if (bus.ptw_resp_valid_i) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_icache_line_buffer.sv
// tb_icache_line_buffer: directed scenario tests for icache_line_buffer (128-bit lines, 4 entries, prefetch on).
module tb_icache_line_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] L1000 = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_DEADBEEF;
    localparam logic [127:0] L1010 = 128'h44444444_33333333_22222222_11111111;

    icache_line_buffer_if #(.ADDR_SIZE(40), .LINE_BITS(128)) bus ();

    icache_line_buffer #(.ADDR_SIZE(40), .LINE_BITS(128), .NUM_ENTRIES(4), .PREFETCH_EN(1)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle;
        bus.fetch_valid_i       = 1'b0;
        bus.fetch_vaddr_i       = '0;
        bus.fetch_flush_i       = 1'b0;
        bus.icache_req_ready_i  = 1'b0;
        bus.icache_resp_valid_i = 1'b0;
        bus.icache_resp_vaddr_i = '0;
        bus.icache_resp_data_i  = '0;
        bus.tlb_miss_i          = 1'b0;
        bus.tlb_xcpt_i          = 1'b0;
        bus.ptw_resp_valid_i    = 1'b0;
    endtask

    task automatic fetch(input logic [39:0] a, input logic rdy);
        idle();
        bus.fetch_valid_i      = 1'b1;
        bus.fetch_vaddr_i      = a;
        bus.icache_req_ready_i = rdy;
    endtask

    task automatic respond(input logic [39:0] a, input logic [127:0] d);
        bus.icache_resp_valid_i = 1'b1;
        bus.icache_resp_vaddr_i = a;
        bus.icache_resp_data_i  = d;
    endtask

    task automatic fill_line(input logic [39:0] a, input logic [127:0] d);
        fetch(a, 1'b1);
        tick();
        fetch(a, 1'b0);
        respond(a, d);
        tick();
        idle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fetch(40'h1000, 1'b1);
        bus.tlb_miss_i = 1'b1;
        tick();
        #1;
        checks++; if (bus.icache_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.icache_req_valid_o); end
        checks++; if (bus.icache_req_kill_o !== 1'b0) begin errors++; $display("FAIL reset_kill: got %b expected 0", bus.icache_req_kill_o); end
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.fetch_resp_valid_o); end
        checks++; if (bus.icache_req_vaddr_o !== 40'h0) begin errors++; $display("FAIL reset_req_vaddr: got %h expected 0", bus.icache_req_vaddr_o); end
        tick();
        idle();
        rst = 1'b0;
    endtask

    task automatic test_cold_miss;
        fetch(40'h1000, 1'b1);
        #1;
        checks++; if (bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL cold_req_valid: got %b expected 1", bus.icache_req_valid_o); end
        checks++; if (bus.icache_req_vaddr_o !== 40'h1000) begin errors++; $display("FAIL cold_req_vaddr: got %h expected 1000", bus.icache_req_vaddr_o); end
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL cold_no_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h1000, 1'b1);
        #1;
        checks++; if (bus.icache_req_valid_o !== 1'b0) begin errors++; $display("FAIL cold_wait_no_req: got %b expected 0", bus.icache_req_valid_o); end
        tick();
        tick();
        respond(40'h1000, L1000);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b1) begin errors++; $display("FAIL cold_fwd_valid: got %b expected 1", bus.fetch_resp_valid_o); end
        checks++; if (bus.fetch_resp_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_fwd_data: got %h expected deadbeef", bus.fetch_resp_data_o); end
        checks++; if (bus.fetch_resp_xcpt_o !== 1'b0) begin errors++; $display("FAIL cold_fwd_xcpt: got %b expected 0", bus.fetch_resp_xcpt_o); end
        tick();
        fetch(40'h1004, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b1) begin errors++; $display("FAIL cold_hit_valid: got %b expected 1", bus.fetch_resp_valid_o); end
        checks++; if (bus.fetch_resp_data_o !== 32'h0A0A0A0A) begin errors++; $display("FAIL cold_hit_data: got %h expected 0a0a0a0a", bus.fetch_resp_data_o); end
        checks++; if (bus.icache_req_vaddr_o !== 40'h1010) begin errors++; $display("FAIL cold_pf_vaddr: got %h expected 1010", bus.icache_req_vaddr_o); end
        tick();
        idle();
    endtask

    task automatic test_prefetch;
        fetch(40'h1008, 1'b1);
        #1;
        checks++; if (bus.fetch_resp_data_o !== 32'h0B0B0B0B) begin errors++; $display("FAIL pf_hit_data: got %h expected 0b0b0b0b", bus.fetch_resp_data_o); end
        checks++; if (bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL pf_req_valid: got %b expected 1", bus.icache_req_valid_o); end
        checks++; if (bus.icache_req_vaddr_o !== 40'h1010) begin errors++; $display("FAIL pf_req_vaddr: got %h expected 1010", bus.icache_req_vaddr_o); end
        tick();
        fetch(40'h1010, 1'b0);
        respond(40'h1010, L1010);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL pf_fill_silent: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h1010, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b1) begin errors++; $display("FAIL pf_hit_valid: got %b expected 1", bus.fetch_resp_valid_o); end
        checks++; if (bus.fetch_resp_data_o !== 32'h11111111) begin errors++; $display("FAIL pf_hit_data: got %h expected 11111111", bus.fetch_resp_data_o); end
        tick();
        idle();
    endtask

    task automatic test_replacement;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) fill_line(40'(i * 16), {4{32'(32'hA0 + i)}});
        fetch(40'h0, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL repl_evicted_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        checks++; if (bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL repl_evicted_req: got %b expected 1", bus.icache_req_valid_o); end
        tick();
        fetch(40'h10, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_data_o !== 32'hA1) begin errors++; $display("FAIL repl_kept_data: got %h expected a1", bus.fetch_resp_data_o); end
        tick();
        fetch(40'h4C, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_data_o !== 32'hA4) begin errors++; $display("FAIL repl_new_data: got %h expected a4", bus.fetch_resp_data_o); end
        tick();
        idle();
    endtask

    task automatic test_tlb_miss;
        fetch(40'h2000, 1'b1);
        tick();
        fetch(40'h2000, 1'b0);
        bus.tlb_miss_i = 1'b1;
        #1;
        checks++; if (bus.icache_req_kill_o !== 1'b1) begin errors++; $display("FAIL tlbm_kill: got %b expected 1", bus.icache_req_kill_o); end
        tick();
        fetch(40'h2000, 1'b1);
        #1;
        checks++; if (bus.icache_req_valid_o !== 1'b0) begin errors++; $display("FAIL tlbm_hold_req: got %b expected 0", bus.icache_req_valid_o); end
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL tlbm_hold_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h2000, 1'b0);
        bus.ptw_resp_valid_i = 1'b1;
        tick();
        fetch(40'h2000, 1'b1);
        #1;
        checks++; if (bus.icache_req_vaddr_o !== 40'h2000 || bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL tlbm_rereq: got valid %b addr %h expected 1 2000", bus.icache_req_valid_o, bus.icache_req_vaddr_o); end
        tick();
        fetch(40'h2008, 1'b0);
        respond(40'h2000, {32'h4, 32'h3, 32'h2, 32'h1});
        #1;
        checks++; if (bus.fetch_resp_data_o !== 32'h3) begin errors++; $display("FAIL tlbm_fill_data: got %h expected 3", bus.fetch_resp_data_o); end
        tick();
        idle();
    endtask

    task automatic test_fault_flush;
        fetch(40'h3000, 1'b1);
        tick();
        fetch(40'h3000, 1'b0);
        bus.tlb_xcpt_i = 1'b1;
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b1) begin errors++; $display("FAIL xcpt_valid: got %b expected 1", bus.fetch_resp_valid_o); end
        checks++; if (bus.fetch_resp_xcpt_o !== 1'b1) begin errors++; $display("FAIL xcpt_flag: got %b expected 1", bus.fetch_resp_xcpt_o); end
        checks++; if (bus.fetch_resp_data_o !== 32'h0) begin errors++; $display("FAIL xcpt_data: got %h expected 0", bus.fetch_resp_data_o); end
        checks++; if (bus.icache_req_kill_o !== 1'b1) begin errors++; $display("FAIL xcpt_kill: got %b expected 1", bus.icache_req_kill_o); end
        tick();
        fetch(40'h3000, 1'b1);
        #1;
        checks++; if (bus.icache_req_valid_o !== 1'b1 || bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL xcpt_no_fill: got req %b resp %b expected 1 0", bus.icache_req_valid_o, bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h3000, 1'b0);
        bus.fetch_flush_i = 1'b1;
        respond(40'h3000, {4{32'h55}});
        #1;
        checks++; if (bus.icache_req_kill_o !== 1'b1) begin errors++; $display("FAIL flush_kill: got %b expected 1", bus.icache_req_kill_o); end
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h3000, 1'b0);
        respond(40'h3000, {4{32'h55}});
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h40, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL flush_cleared: got resp %b req %b expected 0 1", bus.fetch_resp_valid_o, bus.icache_req_valid_o); end
        tick();
        idle();
    endtask

    task automatic test_redirect;
        fetch(40'h8000, 1'b1);
        tick();
        fetch(40'h9000, 1'b0);
        respond(40'h9000, {4{32'h99}});
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL wrong_tag_resp: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h9000, 1'b0);
        respond(40'h8000, {4{32'h88}});
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.icache_req_valid_o !== 1'b0) begin errors++; $display("FAIL redir_fill: got resp %b req %b expected 0 0", bus.fetch_resp_valid_o, bus.icache_req_valid_o); end
        tick();
        fetch(40'h9000, 1'b0);
        #1;
        checks++; if (bus.icache_req_vaddr_o !== 40'h9000 || bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL redir_new_miss: got addr %h resp %b expected 9000 0", bus.icache_req_vaddr_o, bus.fetch_resp_valid_o); end
        tick();
        fetch(40'h8004, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_data_o !== 32'h88) begin errors++; $display("FAIL redir_old_hit: got %h expected 88", bus.fetch_resp_data_o); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_wait;
        fetch(40'h5000, 1'b1);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        fetch(40'h5000, 1'b0);
        respond(40'h5000, {4{32'h77}});
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.icache_req_valid_o !== 1'b1) begin errors++; $display("FAIL rstwait_resp: got resp %b req %b expected 0 1", bus.fetch_resp_valid_o, bus.icache_req_valid_o); end
        tick();
        fetch(40'h5000, 1'b0);
        #1;
        checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin errors++; $display("FAIL rstwait_no_fill: got %b expected 0", bus.fetch_resp_valid_o); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_cold_miss();
        test_prefetch();
        test_replacement();
        test_tlb_miss();
        test_fault_flush();
        test_redirect();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_line_buffer.md
ICACHE_LINE_BUFFER -- requirements
Module: icache_line_buffer

Interface
REQ-001 Parameter ADDR_SIZE, default 40: virtual address width in bits.
REQ-002 Parameter LINE_BITS, default 128: cache line width in bits, a power of two of at least 64; OFFSET = log2(LINE_BITS/8).
REQ-003 Parameter NUM_ENTRIES, default 4: number of line-buffer entries, a power of two from 1 to 8.
REQ-004 Parameter PREFETCH_EN, default 1: enables next-line prefetch.
REQ-005 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 Port fetch_valid_i, input, 1: the fetch stage presents a request this cycle.
REQ-008 Port fetch_vaddr_i, input, ADDR_SIZE: fetch PC; bits [1:0] are ignored.
REQ-009 Port fetch_flush_i, input, 1: invalidate the whole buffer (redirect or fence.i).
REQ-010 Port fetch_resp_valid_o, output, 1: instruction (or exception) returned this cycle.
REQ-011 Port fetch_resp_data_o, output, 32: instruction word.
REQ-012 Port fetch_resp_xcpt_o, output, 1: instruction access fault.
REQ-013 Port icache_req_valid_o, output, 1: line request to the icache.
REQ-014 Port icache_req_ready_i, input, 1: the icache accepts the request.
REQ-015 Port icache_req_vaddr_o, output, ADDR_SIZE: requested address, line-aligned (low OFFSET bits zero).
REQ-016 Port icache_req_kill_o, output, 1: kill the outstanding icache access.
REQ-017 Port icache_resp_valid_i, input, 1: line response valid.
REQ-018 Port icache_resp_vaddr_i, input, ADDR_SIZE: address of the response line.
REQ-019 Port icache_resp_data_i, input, LINE_BITS: response line data.
REQ-020 Port tlb_miss_i, input, 1: TLB miss on the outstanding request.
REQ-021 Port tlb_xcpt_i, input, 1: access fault on the outstanding request.
REQ-022 Port ptw_resp_valid_i, input, 1: page-table walk has completed.

Function
REQ-023 tag(a) = a[ADDR_SIZE-1:OFFSET]; each entry holds a valid bit, a tag and a line.
REQ-024 Hit: fetch_valid_i is high and a valid entry's tag equals tag(fetch_vaddr_i); fetch_resp_valid_o=1 combinationally in the same cycle, data = the 32-bit word selected by fetch_vaddr_i[OFFSET-1:2], word 0 at LSBs.
REQ-025 FSM states:
- IDLE, WAIT, TLBMISS.
- Outstanding tag register otag and prefetch flag opf.
REQ-026 IDLE request selection:
- Demand miss (fetch_valid_i and no hit, no flush): icache_req_valid_o=1 with address tag(fetch_vaddr_i).
- Otherwise, if PREFETCH_EN, a hit on tag T, and T+1 is not resident: prefetch request for T+1.
- Demand always has priority over prefetch.
REQ-027 IDLE->WAIT on icache_req_valid_o and icache_req_ready_i; otag and opf are captured at that edge. icache_req_valid_o is 0 outside IDLE.
REQ-028 WAIT response handling, on icache_resp_valid_i with tag(icache_resp_vaddr_i)==otag and no tlb_xcpt_i:
- Write the entry at round-robin pointer rr with valid=1.
- rr = (rr+1) mod NUM_ENTRIES.
- Next state IDLE.
- If !opf and the fetch request matches otag, forward the response line to fetch in the same cycle.
REQ-029 WAIT responses with a tag not equal to otag are ignored.
REQ-030 WAIT with tlb_xcpt_i:
- fetch_resp_valid_o=1, fetch_resp_xcpt_o=1, data=0, provided !opf.
- No fill; next state IDLE.
- On a prefetch, the exception is silently dropped.
REQ-031 WAIT with tlb_miss_i: next state TLBMISS.
REQ-032 TLBMISS->IDLE on ptw_resp_valid_i or fetch_flush_i; fetch_resp_valid_o=0 in TLBMISS unless a hit occurs.
REQ-033 icache_req_kill_o = tlb_miss_i | tlb_xcpt_i | (fetch_flush_i & state==WAIT).
REQ-034 fetch_flush_i has priority over every other event:
- All valid bits are cleared at the next edge; next state IDLE.
- No request and no response in the flush cycle.
- rr is unchanged.
REQ-035 A fill whose tag is already resident rewrites that entry in place and does not advance rr.
REQ-036 rr wraps from NUM_ENTRIES-1 to 0.
REQ-037 A fetch redirect while in WAIT does not abort: the fill completes, then the new miss is issued from IDLE.

Reset
REQ-038 While rst_i is sampled high:
- State IDLE, all valid bits 0, rr=0, otag=0, opf=0.
- All outputs 0, combinationally overriding hits.
REQ-039 Reset asserted mid-WAIT discards the outstanding request; the later response is ignored because the state is IDLE.

Verification (LINE_BITS=128, NUM_ENTRIES=4, PREFETCH_EN=1)
REQ-040 Cold miss: fetch 0x1000 with ready=1 -> req 0x1000 at cycle 0; response at cycle 3 with word0=0xDEADBEEF -> resp_valid=1, data=0xDEADBEEF at cycle 3, and a hit on 0x1004 at cycle 4.
REQ-041 Prefetch: after the 0x1000 fill, a hit on 0x1008 in IDLE -> req 0x1010 with opf=1; its response fills with no fetch response; fetch 0x1010 then hits the same cycle.
REQ-042 Replacement: fill lines 0x0,0x10,0x20,0x30, then 0x40 -> 0x40 overwrites the 0x0 entry (rr wrapped to 0); fetch 0x0 then misses.
REQ-043 TLB miss: demand 0x2000 then tlb_miss_i in WAIT -> kill=1, state TLBMISS; ptw_resp_valid_i -> IDLE, re-request 0x2000.
REQ-044 Fault and flush: tlb_xcpt_i on demand 0x3000 -> resp_valid=1, xcpt=1, data=0, no fill; flush in WAIT -> kill=1, all valids 0, the stale response ignored.
